// File: rtl/memory_access_lsu_if.sv
// memory_access_lsu_if: data-memory bus with req/gnt/rvalid handshake
`timescale 1ns/1ps
interface memory_access_lsu_if #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 12
);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/memory_access_lsu.sv
// memory_access_lsu: EX/MA stage register driving a req/gnt/rvalid data bus with lane alignment, load extension and fault flags
`timescale 1ns/1ps
module memory_access_lsu #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 12,
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clk_en,
  input  logic i_ex_valid,
  input  logic i_ex_mem_rd,
  input  logic i_ex_mem_wr,
  input  logic i_ex_mem_to_reg,
  input  logic i_ex_reg_wr,
  input  logic [1:0] i_ex_rw_sel,
  input  logic [2:0] i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_pc_plus_4,
  input  logic [XLEN-1:0] i_ex_alu_result,
  input  logic [XLEN-1:0] i_ex_reg_read_data2,
  input  logic [4:0] i_ex_reg_dest,
  output logic o_stall,
  memory_access_lsu_if.master dmem,
  output logic o_ma_valid,
  output logic o_ma_mem_to_reg,
  output logic o_ma_reg_wr,
  output logic [1:0] o_ma_rw_sel,
  output logic [XLEN-1:0] o_ma_pc_plus_4,
  output logic [XLEN-1:0] o_ma_result,
  output logic [XLEN-1:0] o_ma_read_data,
  output logic [4:0] o_ma_reg_dest,
  output logic o_ma_misaligned,
  output logic o_ma_bus_err
);
  localparam int NB = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0] be_q, be_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic we_q, we_d;
  logic [1:0] sz_q, sz_d;
  logic uns_q, uns_d;
  logic [OFS-1:0] off_q, off_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic err_q, err_d;
  logic ma_valid_q, ma_valid_d;
  logic ma_mem_to_reg_q, ma_mem_to_reg_d;
  logic ma_reg_wr_q, ma_reg_wr_d;
  logic [1:0] ma_rw_sel_q, ma_rw_sel_d;
  logic [XLEN-1:0] ma_pc_plus_4_q, ma_pc_plus_4_d;
  logic [XLEN-1:0] ma_result_q, ma_result_d;
  logic [XLEN-1:0] ma_read_data_q, ma_read_data_d;
  logic [4:0] ma_reg_dest_q, ma_reg_dest_d;
  logic ma_misaligned_q, ma_misaligned_d;
  logic ma_bus_err_q, ma_bus_err_d;
  logic [1:0] sz;
  logic [OFS-1:0] off;
  logic acc, illegal, mis, legal, ld_stage, kill;
  logic [15:0] m;
  logic [NB-1:0] be_w;
  logic [XLEN-1:0] wd_w, lane, ext;
  logic signed [XLEN-1:0] sx;
  logic [6:0] sh;
  assign sz = i_ex_funct3[1:0];
  assign off = i_ex_alu_result[OFS-1:0];
  assign acc = i_ex_valid & (i_ex_mem_rd | i_ex_mem_wr);
  assign illegal = (XLEN == 32 && sz == 2'b11) || (XLEN == 32 && i_ex_mem_rd && i_ex_funct3 == 3'b110) || (!i_ex_mem_rd && i_ex_funct3[2]);
  assign mis = acc & (illegal | (|(off & OFS'((1 << sz) - 1))));
  assign legal = acc & ~mis;
  assign m = (16'd1 << (5'd1 << sz)) - 16'd1;
  assign be_w = NB'(m) << off;
  assign wd_w = sz == 2'd0 ? {NB{i_ex_reg_read_data2[7:0]}} : sz == 2'd1 ? {NB/2{i_ex_reg_read_data2[15:0]}} : sz == 2'd2 ? {NB/4{i_ex_reg_read_data2[31:0]}} : i_ex_reg_read_data2;
  assign lane = dmem.rdata >> {off_q, 3'b000};
  assign sh = 7'(XLEN) - (7'd8 << sz_q);
  assign sx = $signed(lane << sh) >>> sh;
  assign ext = uns_q ? (lane << sh) >> sh : sx;
  assign kill = mis | (state_q == DONE & err_q);
  assign o_stall = (state_q != DONE) & (state_q != IDLE | legal);
  assign dmem.req = state_q == REQ;
  assign dmem.we = we_q;
  assign dmem.addr = addr_q;
  assign dmem.be = be_q;
  assign dmem.wdata = wd_q;
  assign o_ma_valid = ma_valid_q;
  assign o_ma_mem_to_reg = ma_mem_to_reg_q;
  assign o_ma_reg_wr = ma_reg_wr_q;
  assign o_ma_rw_sel = ma_rw_sel_q;
  assign o_ma_pc_plus_4 = ma_pc_plus_4_q;
  assign o_ma_result = ma_result_q;
  assign o_ma_read_data = ma_read_data_q;
  assign o_ma_reg_dest = ma_reg_dest_q;
  assign o_ma_misaligned = ma_misaligned_q;
  assign o_ma_bus_err = ma_bus_err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    be_d = be_q;
    wd_d = wd_q;
    we_d = we_q;
    sz_d = sz_q;
    uns_d = uns_q;
    off_d = off_q;
    rd_d = rd_q;
    err_d = err_q;
    ld_stage = 1'b0;
    case (state_q)
      IDLE: begin
        ld_stage = i_clk_en & ~legal;
        if (i_clk_en & legal) begin
          state_d = REQ;
          cnt_d = '0;
          addr_d = {i_ex_alu_result[ADDR_W-1:OFS], OFS'(0)};
          be_d = be_w;
          wd_d = wd_w;
          we_d = ~i_ex_mem_rd;
          sz_d = sz;
          uns_d = i_ex_funct3[2];
          off_d = off;
          rd_d = '0;
          err_d = 1'b0;
        end
      end
      REQ: begin
        if (dmem.gnt) begin
          state_d = we_q ? DONE : WAIT;
          cnt_d = '0;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d = DONE;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      WAIT: begin
        if (dmem.rvalid) begin
          state_d = DONE;
          rd_d = ext;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d = DONE;
          err_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        ld_stage = i_clk_en;
        state_d = i_clk_en ? IDLE : DONE;
      end
    endcase
    ma_valid_d = ld_stage ? i_ex_valid : ma_valid_q;
    ma_mem_to_reg_d = ld_stage ? i_ex_mem_to_reg : ma_mem_to_reg_q;
    ma_reg_wr_d = ld_stage ? i_ex_reg_wr & ~kill : ma_reg_wr_q;
    ma_rw_sel_d = ld_stage ? i_ex_rw_sel : ma_rw_sel_q;
    ma_pc_plus_4_d = ld_stage ? i_ex_pc_plus_4 : ma_pc_plus_4_q;
    ma_result_d = ld_stage ? i_ex_alu_result : ma_result_q;
    ma_read_data_d = ld_stage ? (state_q == DONE ? rd_q : '0) : ma_read_data_q;
    ma_reg_dest_d = ld_stage ? i_ex_reg_dest : ma_reg_dest_q;
    ma_misaligned_d = ld_stage ? mis : ma_misaligned_q;
    ma_bus_err_d = ld_stage ? state_q == DONE & err_q : ma_bus_err_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wd_q <= '0;
      we_q <= 1'b0;
      sz_q <= '0;
      uns_q <= 1'b0;
      off_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
      ma_valid_q <= 1'b0;
      ma_mem_to_reg_q <= 1'b0;
      ma_reg_wr_q <= 1'b0;
      ma_rw_sel_q <= '0;
      ma_pc_plus_4_q <= '0;
      ma_result_q <= '0;
      ma_read_data_q <= '0;
      ma_reg_dest_q <= '0;
      ma_misaligned_q <= 1'b0;
      ma_bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wd_q <= wd_d;
      we_q <= we_d;
      sz_q <= sz_d;
      uns_q <= uns_d;
      off_q <= off_d;
      rd_q <= rd_d;
      err_q <= err_d;
      ma_valid_q <= ma_valid_d;
      ma_mem_to_reg_q <= ma_mem_to_reg_d;
      ma_reg_wr_q <= ma_reg_wr_d;
      ma_rw_sel_q <= ma_rw_sel_d;
      ma_pc_plus_4_q <= ma_pc_plus_4_d;
      ma_result_q <= ma_result_d;
      ma_read_data_q <= ma_read_data_d;
      ma_reg_dest_q <= ma_reg_dest_d;
      ma_misaligned_q <= ma_misaligned_d;
      ma_bus_err_q <= ma_bus_err_d;
    end
  end
endmodule

// File: tb/tb_memory_access_lsu.sv
// tb_memory_access_lsu: scoreboard bench for memory_access_lsu at XLEN 32 and 64
`timescale 1ns/1ps
module tb_memory_access_lsu;
  typedef struct packed {
    int id;
    logic [31:0] res;
    logic [31:0] pc4;
    logic [31:0] rd;
    logic [4:0] dest;
    logic rw;
    logic mis;
    logic err;
  } exp_t;
  typedef struct packed {
    logic [11:0] addr;
    logic [3:0] be;
    logic [31:0] wd;
    logic we;
  } bus_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  logic ex_valid = 1'b0, mrd = 1'b0, mwr = 1'b0, m2r = 1'b0, rwr = 1'b0;
  logic [1:0] rws = '0;
  logic [2:0] f3 = '0;
  logic [31:0] pc4 = '0, alu = '0, rs2 = '0;
  logic [4:0] dest = '0;
  logic stall, ma_valid, ma_m2r, ma_rwr, ma_mis, ma_err;
  logic [1:0] ma_rws;
  logic [31:0] ma_pc4, ma_res, ma_rd;
  logic [4:0] ma_dest;
  logic ev6 = 1'b0, rd6 = 1'b0, wr6 = 1'b0, rw6 = 1'b0;
  logic [2:0] f36 = '0;
  logic [63:0] alu6 = '0, rs26 = '0;
  logic stall6, ma_valid6, ma_m2r6, ma_rwr6, ma_mis6, ma_err6;
  logic [1:0] ma_rws6;
  logic [63:0] ma_pc46, ma_res6, ma_rd6;
  logic [4:0] ma_dest6;
  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  bus_t bus_q[$];
  logic req_p = 1'b0;
  memory_access_lsu_if #(.XLEN(32), .ADDR_W(12)) bus ();
  memory_access_lsu_if #(.XLEN(64), .ADDR_W(12)) b64 ();
  memory_access_lsu #(.XLEN(32), .ADDR_W(12), .MAX_WAIT(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_ex_valid(ex_valid),
    .i_ex_mem_rd(mrd), .i_ex_mem_wr(mwr), .i_ex_mem_to_reg(m2r), .i_ex_reg_wr(rwr),
    .i_ex_rw_sel(rws), .i_ex_funct3(f3), .i_ex_pc_plus_4(pc4), .i_ex_alu_result(alu),
    .i_ex_reg_read_data2(rs2), .i_ex_reg_dest(dest), .o_stall(stall), .dmem(bus.master),
    .o_ma_valid(ma_valid), .o_ma_mem_to_reg(ma_m2r), .o_ma_reg_wr(ma_rwr), .o_ma_rw_sel(ma_rws),
    .o_ma_pc_plus_4(ma_pc4), .o_ma_result(ma_res), .o_ma_read_data(ma_rd), .o_ma_reg_dest(ma_dest),
    .o_ma_misaligned(ma_mis), .o_ma_bus_err(ma_err)
  );
  memory_access_lsu #(.XLEN(64), .ADDR_W(12), .MAX_WAIT(15)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_ex_valid(ev6),
    .i_ex_mem_rd(rd6), .i_ex_mem_wr(wr6), .i_ex_mem_to_reg(rd6), .i_ex_reg_wr(rw6),
    .i_ex_rw_sel(2'b01), .i_ex_funct3(f36), .i_ex_pc_plus_4(64'h0), .i_ex_alu_result(alu6),
    .i_ex_reg_read_data2(rs26), .i_ex_reg_dest(5'd7), .o_stall(stall6), .dmem(b64.master),
    .o_ma_valid(ma_valid6), .o_ma_mem_to_reg(ma_m2r6), .o_ma_reg_wr(ma_rwr6), .o_ma_rw_sel(ma_rws6),
    .o_ma_pc_plus_4(ma_pc46), .o_ma_result(ma_res6), .o_ma_read_data(ma_rd6), .o_ma_reg_dest(ma_dest6),
    .o_ma_misaligned(ma_mis6), .o_ma_bus_err(ma_err6)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (ma_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ma: got valid output want none pending");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("t%0d_result", e.id), 64'(ma_res), 64'(e.res));
        chk($sformatf("t%0d_pc4", e.id), 64'(ma_pc4), 64'(e.pc4));
        chk($sformatf("t%0d_read_data", e.id), 64'(ma_rd), 64'(e.rd));
        chk($sformatf("t%0d_dest", e.id), 64'(ma_dest), 64'(e.dest));
        chk($sformatf("t%0d_reg_wr", e.id), 64'(ma_rwr), 64'(e.rw));
        chk($sformatf("t%0d_misaligned", e.id), 64'(ma_mis), 64'(e.mis));
        chk($sformatf("t%0d_bus_err", e.id), 64'(ma_err), 64'(e.err));
      end
    end
  end
  always @(negedge clk) begin
    if (bus.req && !req_p) begin
      if (bus_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_req: got req at addr %h want no request", bus.addr);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        chk("bus_addr", 64'(bus.addr), 64'(b.addr));
        chk("bus_be", 64'(bus.be), 64'(b.be));
        chk("bus_wdata", 64'(bus.wdata), 64'(b.wd));
        chk("bus_we", 64'(bus.we), 64'(b.we));
      end
    end
    req_p <= bus.req;
  end
  task automatic issue(input int id, input logic rd, input logic wr, input logic rw, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat, input int gd, input int rv,
                       input int exp_stall, input int exp_req, input logic [31:0] exp_rd, input logic exp_rw,
                       input logic exp_mis, input logic exp_err, input logic [11:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
    int ns, reqn, wn;
    bit granted, done;
    ns = 0;
    reqn = 0;
    wn = 0;
    granted = 0;
    done = 0;
    exp_q.push_back('{id: id, res: a, pc4: a + 32'd4, rd: exp_rd, dest: 5'(id), rw: exp_rw, mis: exp_mis, err: exp_err});
    if (exp_req > 0) bus_q.push_back('{addr: exp_addr, be: exp_be, wd: exp_wd, we: ~rd});
    @(negedge clk);
    ex_valid = 1'b1;
    mrd = rd;
    mwr = wr;
    m2r = rd;
    rwr = rw;
    f3 = fn;
    alu = a;
    rs2 = d;
    pc4 = a + 32'd4;
    dest = 5'(id);
    rws = 2'(id);
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (stall) ns++;
      bus.gnt = 1'b0;
      bus.rvalid = 1'b0;
      if (bus.req) begin
        reqn++;
        if (gd >= 0 && reqn == gd + 1) begin
          bus.gnt = 1'b1;
          granted = 1;
        end
      end else if (granted && stall) begin
        wn++;
        if (wn == rv) begin
          bus.rvalid = 1'b1;
          bus.rdata = rdat;
        end
      end
      done = !stall;
      @(posedge clk);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL t%0d_complete: got stall held 64 cycles want release", id);
    end
    chk($sformatf("t%0d_stall_cycles", id), 64'(ns), 64'(exp_stall));
    chk($sformatf("t%0d_req_cycles", id), 64'(reqn), 64'(exp_req));
    @(negedge clk);
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    ex_valid = 1'b0;
    mrd = 1'b0;
    mwr = 1'b0;
  endtask
  initial begin
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    b64.gnt = 1'b0;
    b64.rvalid = 1'b0;
    b64.rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_bus", 64'({bus.req, bus.we, bus.be, bus.addr}), 64'd0);
    chk("rst_ma", 64'(|{ma_valid, ma_m2r, ma_rwr, ma_rws, ma_pc4, ma_res, ma_rd, ma_dest, ma_mis, ma_err}), 64'd0);
    rst = 1'b0;
    issue(1, 0, 1, 0, 3'b000, 32'h103, 32'hA5, 32'h0, 0, 0, 2, 1, 32'h0, 0, 0, 0, 12'h100, 4'b1000, 32'hA5A5A5A5);
    issue(2, 1, 0, 1, 3'b001, 32'h202, 32'h0, 32'h80011234, 0, 2, 4, 1, 32'hFFFF8001, 1, 0, 0, 12'h200, 4'b1100, 32'h0);
    issue(3, 1, 0, 1, 3'b100, 32'h001, 32'h0, 32'h0000F000, 0, 1, 3, 1, 32'h000000F0, 1, 0, 0, 12'h000, 4'b0010, 32'h0);
    issue(4, 1, 0, 1, 3'b010, 32'h006, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 12'h0, 4'h0, 32'h0);
    issue(5, 1, 0, 1, 3'b010, 32'h040, 32'h0, 32'h0, -1, 0, 16, 15, 32'h0, 0, 0, 1, 12'h040, 4'b1111, 32'h0);
    issue(6, 0, 0, 1, 3'b000, 32'h12345678, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 12'h0, 4'h0, 32'h0);
    issue(7, 1, 0, 1, 3'b000, 32'h003, 32'h0, 32'h7F000000, 2, 1, 5, 3, 32'h0000007F, 1, 0, 0, 12'h000, 4'b1000, 32'h0);
    issue(8, 0, 1, 0, 3'b001, 32'h006, 32'h1234BEEF, 32'h0, 0, 0, 2, 1, 32'h0, 0, 0, 0, 12'h004, 4'b1100, 32'hBEEFBEEF);
    issue(9, 0, 1, 1, 3'b100, 32'h000, 32'h11, 32'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 12'h0, 4'h0, 32'h0);
    issue(10, 1, 0, 1, 3'b010, 32'h008, 32'h0, 32'hDEADBEEF, 1, 1, 4, 2, 32'hDEADBEEF, 1, 0, 0, 12'h008, 4'b1111, 32'h0);
    issue(11, 1, 0, 1, 3'b110, 32'h000, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 12'h0, 4'h0, 32'h0);
    issue(12, 1, 1, 1, 3'b010, 32'h00C, 32'h55, 32'hCAFEF00D, 0, 1, 3, 1, 32'hCAFEF00D, 1, 0, 0, 12'h00C, 4'b1111, 32'h55);
    issue(13, 1, 0, 1, 3'b101, 32'h002, 32'h0, 32'h80011234, 0, 1, 3, 1, 32'h00008001, 1, 0, 0, 12'h000, 4'b1100, 32'h0);
    issue(14, 0, 1, 0, 3'b010, 32'hF7FC, 32'hCAFEF00D, 32'h0, 1, 0, 3, 2, 32'h0, 0, 0, 0, 12'h7FC, 4'b1111, 32'hCAFEF00D);
    issue(15, 1, 0, 1, 3'b000, 32'h002, 32'h0, 32'h00800000, 0, 1, 3, 1, 32'hFFFFFF80, 1, 0, 0, 12'h000, 4'b0100, 32'h0);
    bus_q.push_back('{addr: 12'h010, be: 4'b1111, wd: 32'h55, we: 1'b0});
    @(negedge clk);
    ex_valid = 1'b1;
    mrd = 1'b1;
    rwr = 1'b1;
    f3 = 3'b010;
    alu = 32'h010;
    rs2 = 32'h55;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rw_req", 64'(bus.req), 64'd1);
    bus.gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.gnt = 1'b0;
    rst = 1'b1;
    ex_valid = 1'b0;
    mrd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rw_rst_stall", 64'(stall), 64'd0);
    chk("rw_rst_bus", 64'({bus.req, bus.we, bus.be, bus.addr}), 64'd0);
    chk("rw_rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rw_rst_ma", 64'(|{ma_valid, ma_m2r, ma_rwr, ma_rws, ma_pc4, ma_res, ma_rd, ma_dest, ma_mis, ma_err}), 64'd0);
    rst = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 32'h13572468;
    @(posedge clk);
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    chk("rw_late_valid", 64'(ma_valid), 64'd0);
    chk("rw_late_data", 64'(ma_rd), 64'd0);
    chk("rw_late_stall", 64'(stall), 64'd0);
    chk("rw_late_req", 64'(bus.req), 64'd0);
    issue(16, 1, 0, 1, 3'b010, 32'h00C, 32'h0, 32'h0BADF00D, 0, 1, 3, 1, 32'h0BADF00D, 1, 0, 0, 12'h00C, 4'b1111, 32'h0);
    @(negedge clk);
    ev6 = 1'b1;
    wr6 = 1'b1;
    f36 = 3'b011;
    alu6 = 64'h8;
    rs26 = 64'h1122334455667788;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sd_req", 64'(b64.req), 64'd1);
    chk("sd_be", 64'(b64.be), 64'hFF);
    chk("sd_addr", 64'(b64.addr), 64'h008);
    chk("sd_wdata", b64.wdata, 64'h1122334455667788);
    b64.gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    b64.gnt = 1'b0;
    chk("sd_stall", 64'(stall6), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sd_valid", 64'(ma_valid6), 64'd1);
    chk("sd_mis", 64'(ma_mis6), 64'd0);
    wr6 = 1'b0;
    rd6 = 1'b1;
    rw6 = 1'b1;
    alu6 = 64'h4;
    #1;
    chk("ld_stall", 64'(stall6), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("ld_mis", 64'(ma_mis6), 64'd1);
    chk("ld_reg_wr", 64'(ma_rwr6), 64'd0);
    chk("ld_req", 64'(b64.req), 64'd0);
    ev6 = 1'b0;
    rd6 = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
